// File: rtl/slave_write_order_tracker.sv
// Per-slave FIFO of write-address owners {master port, ID}, kept in acceptance order.
// The head owner steers the write-data mux and is retired on the slave's WLAST handshake.
module slave_write_order_tracker #(
   parameter int NUM_MASTERS_WIDTH = 2,
   parameter int MASTERID_WIDTH    = 4,
   parameter int OPEN_WRITE_MAX    = 4,
   parameter int OPEN_WRITE_WIDTH  = 3
) (
   input  logic                         sysClk,
   input  logic                         sysReset,
   input  logic                         awPush,
   input  logic [NUM_MASTERS_WIDTH-1:0] awPushMasterPort,
   input  logic [MASTERID_WIDTH-1:0]    awPushID,
   output logic                         awRoom,
   output logic                         wHeadValid,
   output logic [NUM_MASTERS_WIDTH-1:0] wHeadMasterPort,
   output logic [MASTERID_WIDTH-1:0]    wHeadID,
   input  logic                         wLastPop,
   output logic [OPEN_WRITE_WIDTH-1:0]  openCount,
   output logic                         overflowErr,
   output logic                         underflowErr
);

   localparam int PTR_W = (OPEN_WRITE_MAX > 1) ? $clog2(OPEN_WRITE_MAX) : 1;
   localparam logic [OPEN_WRITE_WIDTH-1:0] DEPTH    = OPEN_WRITE_WIDTH'(OPEN_WRITE_MAX);
   localparam logic [PTR_W-1:0]            LAST_PTR = PTR_W'(OPEN_WRITE_MAX - 1);

   logic [NUM_MASTERS_WIDTH-1:0] r_entPort [OPEN_WRITE_MAX];
   logic [MASTERID_WIDTH-1:0]    r_entID   [OPEN_WRITE_MAX];
   logic [PTR_W-1:0]             r_wrPtr;
   logic [PTR_W-1:0]             r_rdPtr;
   logic [OPEN_WRITE_WIDTH-1:0]  r_count;
   logic                         r_overflow;
   logic                         r_underflow;

   logic w_full;
   logic w_empty;
   logic w_pushOk;
   logic w_popOk;

   // Pointers wrap at D-1 so non-power-of-two depths stay in range.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_full   = (r_count == DEPTH);
   assign w_empty  = (r_count == '0);
   // Acceptance uses the pre-edge count, so a fresh entry can never be popped in its own cycle.
   assign w_pushOk = awPush   && !w_full;
   assign w_popOk  = wLastPop && !w_empty;

   always_ff @(posedge sysClk) begin
      if (w_pushOk) begin
         r_entPort[r_wrPtr] <= awPushMasterPort;
         r_entID[r_wrPtr]   <= awPushID;
      end
   end

   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_pushOk) r_wrPtr <= next_ptr(r_wrPtr);
         if (w_popOk)  r_rdPtr <= next_ptr(r_rdPtr);
         case ({w_pushOk, w_popOk})
            2'b10:   r_count <= r_count + OPEN_WRITE_WIDTH'(1);
            2'b01:   r_count <= r_count - OPEN_WRITE_WIDTH'(1);
            default: r_count <= r_count;
         endcase
         if (awPush && w_full)    r_overflow  <= 1'b1;
         if (wLastPop && w_empty) r_underflow <= 1'b1;
      end
   end

   assign awRoom          = !w_full;
   assign wHeadValid      = !w_empty;
   assign wHeadMasterPort = w_empty ? '0 : r_entPort[r_rdPtr];
   assign wHeadID         = w_empty ? '0 : r_entID[r_rdPtr];
   assign openCount       = r_count;
   assign overflowErr     = r_overflow;
   assign underflowErr    = r_underflow;

endmodule

// File: tb/tb_slave_write_order_tracker.sv
// Bench for slave_write_order_tracker: a D=4 and a D=3 instance share stimulus and are
// compared against queue-based reference models.
module tb_slave_write_order_tracker;

   logic       sysClk = 1'b0;
   logic       sysReset;
   logic       awPush;
   logic [1:0] awPushMasterPort;
   logic [3:0] awPushID;
   logic       wLastPop;

   logic       awRoom4, wHeadValid4, overflowErr4, underflowErr4;
   logic [1:0] wHeadMasterPort4;
   logic [3:0] wHeadID4;
   logic [2:0] openCount4;
   logic       awRoom3, wHeadValid3, overflowErr3, underflowErr3;
   logic [1:0] wHeadMasterPort3;
   logic [3:0] wHeadID3;
   logic [2:0] openCount3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sysClk = ~sysClk;

   slave_write_order_tracker #(
      .NUM_MASTERS_WIDTH(2), .MASTERID_WIDTH(4), .OPEN_WRITE_MAX(4), .OPEN_WRITE_WIDTH(3)
   ) dut4 (
      .sysClk(sysClk), .sysReset(sysReset),
      .awPush(awPush), .awPushMasterPort(awPushMasterPort), .awPushID(awPushID),
      .awRoom(awRoom4), .wHeadValid(wHeadValid4),
      .wHeadMasterPort(wHeadMasterPort4), .wHeadID(wHeadID4),
      .wLastPop(wLastPop), .openCount(openCount4),
      .overflowErr(overflowErr4), .underflowErr(underflowErr4)
   );

   slave_write_order_tracker #(
      .NUM_MASTERS_WIDTH(2), .MASTERID_WIDTH(4), .OPEN_WRITE_MAX(3), .OPEN_WRITE_WIDTH(3)
   ) dut3 (
      .sysClk(sysClk), .sysReset(sysReset),
      .awPush(awPush), .awPushMasterPort(awPushMasterPort), .awPushID(awPushID),
      .awRoom(awRoom3), .wHeadValid(wHeadValid3),
      .wHeadMasterPort(wHeadMasterPort3), .wHeadID(wHeadID3),
      .wLastPop(wLastPop), .openCount(openCount3),
      .overflowErr(overflowErr3), .underflowErr(underflowErr3)
   );

   typedef struct packed {
      logic [1:0] p;
      logic [3:0] id;
   } ent_t;

   ent_t q4[$];
   ent_t q3[$];
   bit   ovf4, unf4, ovf3, unf3;

   localparam logic [12:0] RESET_VEC = 13'b1_0_00_0000_000_0_0;

   // Reference behaviour: owners are served first-in first-out; a full queue refuses
   // new owners, an empty queue has nothing to retire.
   task automatic model_step(input bit push, input ent_t e, input bit pop);
      int n4 = q4.size();
      int n3 = q3.size();
      if (push && n4 == 4) ovf4 = 1;
      if (pop && n4 == 0)  unf4 = 1;
      if (pop && n4 > 0)   void'(q4.pop_front());
      if (push && n4 < 4)  q4.push_back(e);
      if (push && n3 == 3) ovf3 = 1;
      if (pop && n3 == 0)  unf3 = 1;
      if (pop && n3 > 0)   void'(q3.pop_front());
      if (push && n3 < 3)  q3.push_back(e);
   endtask

   task automatic model_reset();
      q4.delete();
      q3.delete();
      ovf4 = 0; unf4 = 0; ovf3 = 0; unf3 = 0;
   endtask

   function automatic logic [12:0] exp4();
      ent_t h = (q4.size() > 0) ? q4[0] : '0;
      return {q4.size() != 4, q4.size() != 0, h.p, h.id, 3'(q4.size()), ovf4, unf4};
   endfunction

   function automatic logic [12:0] exp3();
      ent_t h = (q3.size() > 0) ? q3[0] : '0;
      return {q3.size() != 3, q3.size() != 0, h.p, h.id, 3'(q3.size()), ovf3, unf3};
   endfunction

   function automatic logic [12:0] obs4();
      return {awRoom4, wHeadValid4, wHeadMasterPort4, wHeadID4, openCount4, overflowErr4, underflowErr4};
   endfunction

   function automatic logic [12:0] obs3();
      return {awRoom3, wHeadValid3, wHeadMasterPort3, wHeadID3, openCount3, overflowErr3, underflowErr3};
   endfunction

   task automatic cycle(input bit push, input logic [1:0] port, input logic [3:0] id, input bit pop);
      awPush = push; awPushMasterPort = port; awPushID = id; wLastPop = pop;
      @(posedge sysClk);
      model_step(push, '{p: port, id: id}, pop);
      #1;
      awPush = 0; wLastPop = 0;
   endtask

   task automatic do_reset();
      @(posedge sysClk); #2;
      sysReset = 1;
      model_reset();
      @(posedge sysClk); #2;
      sysReset = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (obs4() !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_d4 actual=%b required=%b", obs4(), RESET_VEC);
      end
      n_checks++;
      if (obs3() !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_d3 actual=%b required=%b", obs3(), RESET_VEC);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      cycle(1, 2'd1, 4'd3, 0);
      n_checks++;
      if ({wHeadValid4, wHeadMasterPort4, wHeadID4} !== {1'b1, 2'd1, 4'd3}) begin
         n_fail++; $display("FAIL first_push_latency actual=%b/%0d/%0d required=1/1/3",
                            wHeadValid4, wHeadMasterPort4, wHeadID4);
      end
      cycle(1, 2'd2, 4'd5, 0);
      n_checks++;
      if ({openCount4, wHeadMasterPort4, wHeadID4} !== {3'd2, 2'd1, 4'd3}) begin
         n_fail++; $display("FAIL two_push actual=cnt%0d head(%0d,%0d) required=cnt2 head(1,3)",
                            openCount4, wHeadMasterPort4, wHeadID4);
      end
      cycle(0, 2'd0, 4'd0, 1);
      n_checks++;
      if ({openCount4, wHeadMasterPort4, wHeadID4} !== {3'd1, 2'd2, 4'd5}) begin
         n_fail++; $display("FAIL pop_advance actual=cnt%0d head(%0d,%0d) required=cnt1 head(2,5)",
                            openCount4, wHeadMasterPort4, wHeadID4);
      end
      n_checks++;
      if (obs3() !== exp3()) begin
         n_fail++; $display("FAIL push_pop_d3 actual=%b required=%b", obs3(), exp3());
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 2'(i), 4'(i + 8), 0);
      n_checks++;
      if ({openCount4, awRoom4, overflowErr4} !== {3'd4, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL full_d4 actual=cnt%0d room%0d ovf%0d required=cnt4 room0 ovf0",
                            openCount4, awRoom4, overflowErr4);
      end
      cycle(1, 2'd3, 4'd15, 0);
      n_checks++;
      if ({openCount4, overflowErr4, wHeadMasterPort4, wHeadID4} !== {3'd4, 1'b1, 2'd0, 4'd8}) begin
         n_fail++; $display("FAIL overflow_d4 actual=cnt%0d ovf%0d head(%0d,%0d) required=cnt4 ovf1 head(0,8)",
                            openCount4, overflowErr4, wHeadMasterPort4, wHeadID4);
      end
      n_checks++;
      if (obs3() !== exp3()) begin
         n_fail++; $display("FAIL overflow_d3 actual=%b required=%b", obs3(), exp3());
      end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 2'd0, 4'd0, 1);
         n_checks++;
         if (obs4() !== exp4()) begin
            n_fail++; $display("FAIL drain_d4 step=%0d actual=%b required=%b", i, obs4(), exp4());
         end
      end
   endtask

   task automatic test_wrap_d3();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         cycle(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), i >= 2 && (i % 2 == 0));
         n_checks++;
         if (obs3() !== exp3()) begin
            n_fail++; $display("FAIL wrap_d3 push=%0d actual=%b required=%b", i, obs3(), exp3());
         end
      end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 2'd0, 4'd0, 1);
         n_checks++;
         if (obs3() !== exp3()) begin
            n_fail++; $display("FAIL wrap_drain_d3 step=%0d actual=%b required=%b", i, obs3(), exp3());
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cycle(1, 2'd1, 4'd1, 0);
      cycle(1, 2'd2, 4'd2, 0);
      cycle(1, 2'd3, 4'd3, 1);
      n_checks++;
      if ({openCount4, wHeadMasterPort4, wHeadID4, underflowErr4} !== {3'd2, 2'd2, 4'd2, 1'b0}) begin
         n_fail++; $display("FAIL simul_partial actual=cnt%0d head(%0d,%0d) unf%0d required=cnt2 head(2,2) unf0",
                            openCount4, wHeadMasterPort4, wHeadID4, underflowErr4);
      end
      cycle(0, 2'd0, 4'd0, 1);
      cycle(0, 2'd0, 4'd0, 1);
      cycle(1, 2'd3, 4'd12, 1);
      n_checks++;
      if ({openCount4, underflowErr4, wHeadValid4, wHeadMasterPort4, wHeadID4} !==
          {3'd1, 1'b1, 1'b1, 2'd3, 4'd12}) begin
         n_fail++; $display("FAIL simul_empty actual=cnt%0d unf%0d hv%0d head(%0d,%0d) required=cnt1 unf1 hv1 head(3,12)",
                            openCount4, underflowErr4, wHeadValid4, wHeadMasterPort4, wHeadID4);
      end
      n_checks++;
      if (obs3() !== exp3()) begin
         n_fail++; $display("FAIL simul_d3 actual=%b required=%b", obs3(), exp3());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom % 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               ($urandom % 2) != 0);
         n_checks++;
         if (obs4() !== exp4()) begin
            n_fail++; $display("FAIL random_d4 cyc=%0d actual=%b required=%b", i, obs4(), exp4());
         end
         n_checks++;
         if (obs3() !== exp3()) begin
            n_fail++; $display("FAIL random_d3 cyc=%0d actual=%b required=%b", i, obs3(), exp3());
         end
      end
   endtask

   task automatic test_reset_midway();
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 2'(i + 1), 4'(i + 4), 0);
      #2;
      sysReset = 1;
      model_reset();
      #1;
      n_checks++;
      if (obs4() !== RESET_VEC) begin
         n_fail++; $display("FAIL async_reset_d4 actual=%b required=%b", obs4(), RESET_VEC);
      end
      n_checks++;
      if (obs3() !== RESET_VEC) begin
         n_fail++; $display("FAIL async_reset_d3 actual=%b required=%b", obs3(), RESET_VEC);
      end
      @(posedge sysClk); #2;
      sysReset = 0;
      cycle(1, 2'd2, 4'd9, 0);
      n_checks++;
      if ({openCount4, wHeadMasterPort4, wHeadID4} !== {3'd1, 2'd2, 4'd9}) begin
         n_fail++; $display("FAIL post_reset_head actual=cnt%0d head(%0d,%0d) required=cnt1 head(2,9)",
                            openCount4, wHeadMasterPort4, wHeadID4);
      end
   endtask

   initial begin
      sysReset = 1; awPush = 0; awPushMasterPort = '0; awPushID = '0; wLastPop = 0;
      model_reset();
      repeat (2) @(posedge sysClk);
      #1;
      sysReset = 0;
      test_reset();
      test_push_pop();
      test_full();
      test_wrap_d3();
      test_simultaneous();
      test_random();
      test_reset_midway();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
